// File: rtl/conv_job_sched_pkg.sv
// Shared types and constants for the conv engine job scheduler.
package conv_job_sched_pkg;

    // One-hot, matching the conv engine's own state encoding.
    typedef enum logic [5:0] {
        ST_IDLE      = 6'b000001,
        ST_FETCH     = 6'b000010,
        ST_LAUNCH    = 6'b000100,
        ST_WAIT_ACK  = 6'b001000,
        ST_WAIT_DONE = 6'b010000,
        ST_DONE      = 6'b100000
    } state_e;

    typedef enum logic [1:0] {
        WD_IDLE,
        WD_ACK,
        WD_BUSY
    } wd_phase_e;

    localparam logic [15:0] TERMINATOR = 16'hFFFF;
    localparam int          DESC_WORDS = 3;

    function automatic logic [11:0] desc_addr(input logic [11:0] base, input logic [1:0] offs);
        return base + 12'(offs);
    endfunction

endpackage

// File: rtl/conv_job_sched_if.sv
// Host control, descriptor SRAM read port and conv engine pins of the job scheduler.
interface conv_job_sched_if;
    logic        host_run;
    logic        host_busy;
    logic        host_done;
    logic        host_err;
    logic [4:0]  host_jobs;
    logic [11:0] desc_read_address;
    logic [15:0] desc_read_data;
    logic        eng_run;
    logic        eng_busy;
    logic [11:0] eng_in_base;
    logic [11:0] eng_wmem_addr;
    logic [11:0] eng_out_base;

    modport master (
        input  host_run, desc_read_data, eng_busy,
        output host_busy, host_done, host_err, host_jobs, desc_read_address,
               eng_run, eng_in_base, eng_wmem_addr, eng_out_base
    );

    modport slave (
        output host_run, desc_read_data, eng_busy,
        input  host_busy, host_done, host_err, host_jobs, desc_read_address,
               eng_run, eng_in_base, eng_wmem_addr, eng_out_base
    );
endinterface

// File: rtl/conv_job_sched_job_watchdog.sv
// Engine handshake watchdog: ack window after start, then busy-length limit.
module job_watchdog
    import conv_job_sched_pkg::*;
#(
    parameter int ACK_WINDOW = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic ack,
    input  logic busy,
    output logic ack_err,
    output logic to_err
);

    localparam int CW = $clog2((TIMEOUT > ACK_WINDOW ? TIMEOUT : ACK_WINDOW) + 1);

    wd_phase_e       phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // The start cycle is the first cycle of the ack window and the ack cycle is
    // the first busy cycle, so both loads are one less than the limit.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        ack_err = 1'b0;
        to_err  = 1'b0;
        if (start) begin
            phase_d = WD_ACK;
            cnt_d   = CW'(ACK_WINDOW - 1);
        end else begin
            case (phase_q)
                WD_ACK: begin
                    if (ack) begin
                        phase_d = WD_BUSY;
                        cnt_d   = CW'(TIMEOUT - 1);
                    end else if (cnt_q <= CW'(1)) begin
                        ack_err = 1'b1;
                        phase_d = WD_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                WD_BUSY: begin
                    if (!busy) begin
                        phase_d = WD_IDLE;
                    end else if (cnt_q <= CW'(1)) begin
                        to_err  = 1'b1;
                        phase_d = WD_IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= WD_IDLE;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/conv_job_sched.sv
// Walks the descriptor list, programs the conv engine per job and runs it to completion.
//   state     | meaning
//   IDLE      | waiting for host_run
//   FETCH     | 4-cycle read of the 3-word descriptor (fc = 0..3)
//   LAUNCH    | new bases on eng_*, eng_run pulse
//   WAIT_ACK  | waiting for eng_busy to rise
//   WAIT_DONE | waiting for eng_busy to fall
//   DONE      | host_done pulse
module conv_job_sched
    import conv_job_sched_pkg::*;
#(
    parameter logic [11:0] DESC_BASE  = 12'h000,
    parameter int          MAX_JOBS   = 16,
    parameter int          ACK_WINDOW = 4,
    parameter int          TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              reset,
    conv_job_sched_if.master  bus
);

    state_e      state_q, state_d;
    logic [1:0]  fc_q, fc_d;
    logic [11:0] ptr_q, ptr_d, addr_q, addr_d;
    logic [11:0] w0_q, w0_d, w1_q, w1_d;
    logic [11:0] in_q, in_d, wmem_q, wmem_d, out_q, out_d;
    logic [4:0]  jobs_q, jobs_d, jobs_inc;
    logic        err_q, err_d;
    logic        ack_err, to_err;

    assign jobs_inc = jobs_q + 5'd1;

    job_watchdog #(
        .ACK_WINDOW (ACK_WINDOW),
        .TIMEOUT    (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .start   (state_q == ST_LAUNCH),
        .ack     (bus.eng_busy),
        .busy    (bus.eng_busy),
        .ack_err (ack_err),
        .to_err  (to_err)
    );

    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        in_d    = in_q;
        wmem_d  = wmem_q;
        out_d   = out_q;
        jobs_d  = jobs_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.host_run) begin
                    ptr_d   = DESC_BASE;
                    addr_d  = DESC_BASE;
                    fc_d    = 2'd0;
                    jobs_d  = '0;
                    err_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                fc_d = fc_q + 2'd1;
                if (fc_q < 2'd2) addr_d = desc_addr(ptr_q, fc_q + 2'd1);
                // Read data lags the address by one cycle: word fc-1 arrives at fc.
                case (fc_q)
                    2'd0: ;
                    2'd1: begin
                        if (bus.desc_read_data == TERMINATOR) state_d = ST_DONE;
                        else                                  w0_d    = bus.desc_read_data[11:0];
                    end
                    2'd2: w1_d = bus.desc_read_data[11:0];
                    default: begin
                        in_d    = w0_q;
                        wmem_d  = w1_q;
                        out_d   = bus.desc_read_data[11:0];
                        ptr_d   = ptr_q + 12'(DESC_WORDS);
                        state_d = ST_LAUNCH;
                    end
                endcase
            end
            ST_LAUNCH: state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (ack_err) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (bus.eng_busy) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.eng_busy) begin
                    jobs_d = jobs_inc;
                    if (jobs_inc == 5'(MAX_JOBS)) begin
                        state_d = ST_DONE;
                    end else begin
                        fc_d    = 2'd0;
                        addr_d  = ptr_q;
                        state_d = ST_FETCH;
                    end
                end else if (to_err) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            fc_q    <= 2'd0;
            ptr_q   <= DESC_BASE;
            addr_q  <= DESC_BASE;
            w0_q    <= '0;
            w1_q    <= '0;
            in_q    <= '0;
            wmem_q  <= '0;
            out_q   <= '0;
            jobs_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            in_q    <= in_d;
            wmem_q  <= wmem_d;
            out_q   <= out_d;
            jobs_q  <= jobs_d;
            err_q   <= err_d;
        end
    end

    assign bus.host_busy         = !(state_q inside {ST_IDLE, ST_DONE});
    assign bus.host_done         = (state_q == ST_DONE);
    assign bus.host_err          = err_q;
    assign bus.host_jobs         = jobs_q;
    assign bus.desc_read_address = addr_q;
    assign bus.eng_run           = (state_q == ST_LAUNCH);
    assign bus.eng_in_base       = in_q;
    assign bus.eng_wmem_addr     = wmem_q;
    assign bus.eng_out_base      = out_q;

endmodule
